// File: rtl/fuzzy_risk_sched.sv
// fuzzy_risk_sched: round-robin scheduler sharing one fuzzy risk evaluator
// between NCH sensor channels, with a valid/ready result port and a
// per-channel hysteresis alarm.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req[NCH]              per-channel level request, held until its ack
//   raw_bus, sow_bus      per-channel 8b rain/soil readings, ch i at [8i+7:8i]
//   ack[NCH]              one-hot pulse while the channel's risk is captured
//   fz_raw, fz_sow        readings presented to the evaluator
//   fz_ef                 evaluator enable, one-cycle pulse
//   fz_risk               risk returned by the evaluator (registered on fz_ef)
//   res_valid/res_ready   result handshake
//   res_ch, res_risk      channel and risk of the pending result
//   alarm[NCH]            per-channel hysteresis alarm
//   busy                  high whenever the scheduler is not idle
module fuzzy_risk_sched #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CHW      = 2,
    parameter int unsigned ALARM_HI = 200,
    parameter int unsigned ALARM_LO = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic [NCH*8-1:0] raw_bus,
    input  logic [NCH*8-1:0] sow_bus,
    output logic [NCH-1:0]   ack,
    output logic [7:0]       fz_raw,
    output logic [7:0]       fz_sow,
    output logic             fz_ef,
    input  logic [7:0]       fz_risk,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CHW-1:0]   res_ch,
    output logic [7:0]       res_risk,
    output logic [NCH-1:0]   alarm,
    output logic             busy
);

    localparam int unsigned DW = 8;
    localparam logic [DW-1:0] HI_TH = DW'(ALARM_HI);
    localparam logic [DW-1:0] LO_TH = DW'(ALARM_LO);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_d;

    logic [CHW-1:0] cur, cur_d;
    logic [CHW-1:0] last, last_d;

    logic [DW-1:0]  fz_raw_d, fz_sow_d, res_risk_d;
    logic           fz_ef_d, res_valid_d, busy_d;
    logic [NCH-1:0] ack_d, alarm_d;
    logic [CHW-1:0] res_ch_d;

    logic           grant_found;
    logic [CHW-1:0] grant_idx;

    // Round-robin search: first requester after the last granted channel.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            int unsigned idx;
            idx = (int'(last) + k) % NCH;
            if (!grant_found && req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CHW'(idx);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        cur_d       = cur;
        last_d      = last;
        fz_raw_d    = fz_raw;
        fz_sow_d    = fz_sow;
        fz_ef_d     = 1'b0;
        ack_d       = '0;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch;
        res_risk_d  = res_risk;
        alarm_d     = alarm;

        unique case (state)
            IDLE: begin
                if (grant_found) begin
                    fz_raw_d = raw_bus[DW*int'(grant_idx) +: DW];
                    fz_sow_d = sow_bus[DW*int'(grant_idx) +: DW];
                    cur_d    = grant_idx;
                    last_d   = grant_idx;
                    fz_ef_d  = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // ack is registered, so it is raised here to be seen during CAPT
                ack_d   = NCH'(1) << cur;
                state_d = CAPT;
            end
            CAPT: begin
                res_risk_d  = fz_risk;
                res_ch_d    = cur;
                res_valid_d = 1'b1;
                if (fz_risk >= HI_TH) begin
                    alarm_d[cur] = 1'b1;
                end else if (fz_risk < LO_TH) begin
                    alarm_d[cur] = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            last      <= CHW'(NCH - 1);
            fz_raw    <= '0;
            fz_sow    <= '0;
            fz_ef     <= 1'b0;
            ack       <= '0;
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_risk  <= '0;
            alarm     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            cur       <= cur_d;
            last      <= last_d;
            fz_raw    <= fz_raw_d;
            fz_sow    <= fz_sow_d;
            fz_ef     <= fz_ef_d;
            ack       <= ack_d;
            res_valid <= res_valid_d;
            res_ch    <= res_ch_d;
            res_risk  <= res_risk_d;
            alarm     <= alarm_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_fuzzy_risk_sched.sv
// Testbench for fuzzy_risk_sched with a behavioural evaluator in the loop.
module tb_fuzzy_risk_sched;

    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int HI  = 200;
    localparam int LO  = 150;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   req;
    logic [NCH*8-1:0] raw_bus, sow_bus;
    logic [NCH-1:0]   ack;
    logic [7:0]       fz_raw, fz_sow, fz_risk;
    logic             fz_ef;
    logic             res_valid, res_ready;
    logic [CHW-1:0]   res_ch;
    logic [7:0]       res_risk;
    logic [NCH-1:0]   alarm;
    logic             busy;

    fuzzy_risk_sched #(.NCH(NCH), .CHW(CHW), .ALARM_HI(HI), .ALARM_LO(LO)) dut (
        .clk(clk), .rst(rst), .req(req), .raw_bus(raw_bus), .sow_bus(sow_bus),
        .ack(ack), .fz_raw(fz_raw), .fz_sow(fz_sow), .fz_ef(fz_ef), .fz_risk(fz_risk),
        .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
        .res_risk(res_risk), .alarm(alarm), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in evaluator: risk steps by 85 per band of the mean reading.
    function automatic logic [7:0] eval_risk(input int r, input int s);
        int avg;
        avg = (r + s) / 2;
        if (avg >= 80)      return 8'd255;
        else if (avg >= 50) return 8'd170;
        else if (avg >= 20) return 8'd85;
        else                return 8'd0;
    endfunction

    always @(posedge clk) begin
        if (fz_ef) fz_risk <= eval_risk(int'(fz_raw), int'(fz_sow));
    end

    typedef struct {
        int         ch;
        logic [7:0] risk;
        logic       al;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    res_t res_q[$];
    int   ack_q[$];
    int   raw_v[NCH];
    int   sow_v[NCH];
    logic exp_alarm[NCH];
    int   m_last;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_data();
        for (int i = 0; i < NCH; i++) begin
            raw_bus[8*i +: 8] = 8'(raw_v[i]);
            sow_bus[8*i +: 8] = 8'(sow_v[i]);
        end
    endtask

    // Reference: serve the pending set in rotating order starting after m_last.
    task automatic model_batch(input logic [NCH-1:0] mask);
        logic [NCH-1:0] pend;
        pend = mask;
        while (pend != 0) begin
            int c;
            res_t r;
            c = 0;
            for (int k = 1; k <= NCH; k++) begin
                c = (m_last + k) % NCH;
                if (pend[c]) break;
            end
            pend[c] = 1'b0;
            m_last  = c;
            r.ch    = c;
            r.risk  = eval_risk(raw_v[c], sow_v[c]);
            if (int'(r.risk) >= HI)     exp_alarm[c] = 1'b1;
            else if (int'(r.risk) < LO) exp_alarm[c] = 1'b0;
            r.al = exp_alarm[c];
            ack_q.push_back(c);
            res_q.push_back(r);
        end
    endtask

    // Monitor: compares acks and accepted results against the scoreboard.
    logic       stalled = 1'b0;
    logic [1:0] hold_ch;
    logic [7:0] hold_risk;
    always @(negedge clk) begin
        if (!rst) begin
            if (ack != '0) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", int'(ack), 0);
                end else begin
                    int e;
                    e = ack_q.pop_front();
                    chk("ack_onehot", int'(ack), 1 << e);
                end
            end
            if (res_valid) begin
                chk("ef_during_done", int'(fz_ef), 0);
                if (stalled) begin
                    chk("stall_res_ch", int'(res_ch), int'(hold_ch));
                    chk("stall_res_risk", int'(res_risk), int'(hold_risk));
                end
                if (res_ready) begin
                    if (res_q.size() == 0) begin
                        chk("res_unexpected", 1, 0);
                    end else begin
                        res_t r;
                        r = res_q.pop_front();
                        chk("res_ch", int'(res_ch), r.ch);
                        chk("res_risk", int'(res_risk), int'(r.risk));
                        chk("alarm_bit", int'(alarm[res_ch]), int'(r.al));
                    end
                end
                stalled   = !res_ready;
                hold_ch   = res_ch;
                hold_risk = res_risk;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Issue a request set, drop each bit on its ack, wait for all results.
    task automatic run_batch(input logic [NCH-1:0] mask, input bit rnd_ready);
        int  prev_ack;
        bit  done;
        prev_ack = -1;
        done     = 1'b0;
        model_batch(mask);
        req = mask;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk); #1;
            if (ack != '0) begin
                if (!rnd_ready && prev_ack >= 0) chk("ack_spacing", cyc - prev_ack, 4);
                prev_ack = cyc;
            end
            req       = req & ~ack;
            res_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (req == '0 && res_q.size() == 0 && ack_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("batch_timeout", int'(done), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_last = NCH - 1;
        for (int i = 0; i < NCH; i++) exp_alarm[i] = 1'b0;
        res_q.delete();
        ack_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        req       = '1;
        res_ready = 1'b0;
        raw_bus   = '0;
        sow_bus   = '0;
        for (int i = 0; i < NCH; i++) begin
            raw_v[i] = 0;
            sow_v[i] = 0;
        end

        // Reset with all requests asserted: everything stays at zero.
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_ef", int'(fz_ef), 0);
            chk("rst_ack", int'(ack), 0);
            chk("rst_valid", int'(res_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_alarm", int'(alarm), 0);
            chk("rst_fz_raw", int'(fz_raw), 0);
        end
        req = '0;
        do_reset();

        // Single request on ch0: latency T+1 ef, T+2 ack, T+3 valid.
        raw_v[0] = 80; sow_v[0] = 80; set_data();
        res_ready = 1'b1;
        model_batch(4'b0001);
        req = 4'b0001;
        @(negedge clk); chk("lat_ef_T", int'(fz_ef), 0);
        @(negedge clk); chk("lat_ef_T1", int'(fz_ef), 1);
        chk("lat_fz_raw", int'(fz_raw), 80);
        chk("lat_busy", int'(busy), 1);
        @(negedge clk); chk("lat_ack_T2", int'(ack), 1);
        chk("lat_ef_off", int'(fz_ef), 0);
        @(posedge clk); #1; req = '0;
        @(negedge clk); chk("lat_valid_T3", int'(res_valid), 1);
        chk("lat_alarm0", int'(alarm[0]), 1);
        @(posedge clk); #1;
        chk("single_drained", res_q.size(), 0);

        // Distinct values on each channel, then all four held together.
        raw_v[1] = 50; sow_v[1] = 50;
        raw_v[2] = 20; sow_v[2] = 20;
        raw_v[3] = 0;  sow_v[3] = 0;
        set_data();
        run_batch(4'b1110, 1'b0);
        run_batch(4'b1111, 1'b0);

        // Backpressure on ch1's result while ch2 waits.
        begin
            bit seen;
            seen = 1'b0;
            res_ready = 1'b0;
            model_batch(4'b0110);
            req = 4'b0110;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(posedge clk); #1;
                req = req & ~ack;
                seen = res_valid;
            end
            chk("bp_reach_done", int'(seen), 1);
            repeat (5) begin
                @(negedge clk);
                chk("bp_valid_held", int'(res_valid), 1);
                chk("bp_no_ef", int'(fz_ef), 0);
            end
            @(posedge clk); #1; res_ready = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("bp_next_ef", int'(fz_ef), 1);
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1;
                req = req & ~ack;
            end
            chk("bp_drained", res_q.size(), 0);
        end

        // Hysteresis on ch0: 255 sets, 170 holds, 85 clears.
        raw_v[0] = 80; sow_v[0] = 80; set_data(); run_batch(4'b0001, 1'b0);
        raw_v[0] = 50; sow_v[0] = 50; set_data(); run_batch(4'b0001, 1'b0);
        raw_v[0] = 20; sow_v[0] = 20; set_data(); run_batch(4'b0001, 1'b0);

        // Randomized request sets, readings and backpressure.
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < NCH; i++) begin
                raw_v[i] = $urandom_range(0, 110);
                sow_v[i] = $urandom_range(0, 110);
            end
            set_data();
            run_batch(4'($urandom_range(1, 15)), 1'b1);
        end

        // Reset replacing the capture: no ack, no result, alarms cleared.
        begin
            bit seen;
            seen = 1'b0;
            res_ready = 1'b1;
            raw_v[2] = 90; sow_v[2] = 90; set_data();
            req = 4'b0100;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(posedge clk); #1;
                seen = fz_ef;
            end
            chk("abort_ef_seen", int'(seen), 1);
            rst = 1'b1;
            req = '0;
            repeat (3) begin
                @(negedge clk);
                chk("abort_ack", int'(ack), 0);
                chk("abort_valid", int'(res_valid), 0);
            end
            chk("abort_alarm", int'(alarm), 0);
            @(posedge clk); #1;
            rst = 1'b0;
            m_last = NCH - 1;
            for (int i = 0; i < NCH; i++) exp_alarm[i] = 1'b0;
            repeat (4) begin
                @(negedge clk);
                chk("abort_idle", int'(busy), 0);
            end
        end

        // Channel 0 is first again after reset.
        raw_v[0] = 50; sow_v[0] = 50; set_data();
        run_batch(4'b0101, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
